// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared types and the int<->float conversion functions for fcvt_arbiter
package fcvt_pkg;
  typedef enum logic {OP_ITOF, OP_FTOI} fcvt_op_t;
  typedef struct packed {
    fcvt_op_t    op;
    logic [31:0] data;
    logic        src;
  } fcvt_s1_t;
  // int32 -> single, round-half-up on the magnitude
  function automatic logic [31:0] itof(input logic [31:0] a);
    logic [31:0] mag, norm;
    logic [4:0]  p;
    logic [24:0] sum;
    logic [7:0]  e;
    mag = a[31] ? -a : a;
    p = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = 5'(i);
    norm = mag << (5'd31 - p);
    sum = {1'b0, norm[31:8]} + 25'(norm[7]);
    e = 8'd127 + {3'b0, p} + {7'b0, sum[24]};
    return (a == '0) ? '0 : {a[31], e, sum[24] ? 23'd0 : sum[22:0]};
  endfunction
  // single -> int32, round-half-away-from-zero; out-of-range inputs are undefined
  function automatic logic [31:0] ftoi(input logic [31:0] a);
    logic [23:0] m;
    logic [7:0]  e;
    logic [31:0] r, mag;
    m = {1'b1, a[22:0]};
    e = a[30:23];
    r = {7'b0, m, 1'b0} >> (8'd150 - e);
    mag = (e >= 8'd150) ? ({8'b0, m} << (e - 8'd150)) : ((r >> 1) + {31'b0, r[0]});
    return a[31] ? -mag : mag;
  endfunction
endpackage

// File: rtl/fcvt_rr_arb.sv
// fcvt_rr_arb: 2-way round-robin arbiter; rr_ptr flips only when both requesters contend
module fcvt_rr_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] valid,
  input  logic       adv,
  output logic       grant,
  output logic [1:0] ready,
  output logic       accept
);
  logic rr_ptr;
  assign grant  = (&valid) ? rr_ptr : valid[1];
  assign ready  = adv ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept = |(valid & ready);
  always_ff @(posedge clk) begin
    if (!rstn) rr_ptr <= 1'b0;
    else if (accept && (&valid)) rr_ptr <= ~grant;
  end
endmodule

// File: rtl/fcvt_arbiter.sv
// fcvt_arbiter: two requesters share one registered itof/ftoi datapath (S1 operand, S2 result).
// Define FCVT_PERF_EN to add the perf_conflict / perf_stall counters and ports.
module fcvt_arbiter
  import fcvt_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  fcvt_op_t         req0_op,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  fcvt_op_t         req1_op,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src
`ifdef FCVT_PERF_EN
  ,
  output logic [31:0]      perf_conflict,
  output logic [31:0]      perf_stall
`endif
);
  logic             adv_s1, adv_s2, grant, accept, s1_valid;
  logic [1:0]       ready;
  fcvt_s1_t         s1, s1_in;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      conv;
  assign adv_s2 = ~res_valid | res_ready;
  assign adv_s1 = ~s1_valid | adv_s2;
  fcvt_rr_arb u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .valid ({req1_valid, req0_valid}),
    .adv   (adv_s1),
    .grant (grant),
    .ready (ready),
    .accept(accept)
  );
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign s1_in = grant ? {req1_op, req1_data, 1'b1} : {req0_op, req0_data, 1'b0};
  assign conv  = (s1.op == OP_FTOI) ? ftoi(s1.data) : itof(s1.data);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s1_tag   <= '0;
    end else if (adv_s1) begin
      s1_valid <= accept;
      if (accept) begin
        s1     <= s1_in;
        s1_tag <= grant ? req1_tag : req0_tag;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_src   <= 1'b0;
    end else if (adv_s2) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_data <= conv;
        res_tag  <= s1_tag;
        res_src  <= s1.src;
      end
    end
  end
`ifdef FCVT_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_conflict <= '0;
      perf_stall    <= '0;
    end else begin
      perf_conflict <= perf_conflict + 32'(req0_valid & req1_valid);
      perf_stall    <= perf_stall + 32'(res_valid & ~res_ready);
    end
  end
`endif
endmodule

// File: tb/tb_fcvt_arbiter.sv
// tb_fcvt_arbiter: directed and random checks of fcvt_arbiter against a real-arithmetic reference model.
// Builds with or without FCVT_PERF_EN.
module tb_fcvt_arbiter;
  import fcvt_pkg::*;
  localparam int TAG_W = 5;

  logic             clk = 1'b0, rstn = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
  fcvt_op_t         req0_op = OP_ITOF, req1_op = OP_ITOF;
  logic [31:0]      req0_data = '0, req1_data = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             req0_ready, req1_ready, res_valid, res_src;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
`ifdef FCVT_PERF_EN
  logic [31:0]      perf_conflict, perf_stall;
`endif

  fcvt_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_src(res_src)
`ifdef FCVT_PERF_EN
    , .perf_conflict(perf_conflict), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             src;
  } exp_t;
  exp_t sb[$];
  exp_t ex;
  logic        rr_m = 1'b0, acc0 = 1'b0, acc1 = 1'b0, stall_prev = 1'b0, both, g_m;
  logic [1:0]  exp_rdy;
  logic [38:0] snap;

  function automatic logic [31:0] m_itof(input logic [31:0] a);
    longint v, mag, q;
    int e;
    v = longint'($signed(a));
    mag = v < 0 ? -v : v;
    if (mag == 0) return 32'h0;
    e = 0;
    while ((longint'(1) << (e + 1)) <= mag) e++;
    q = (e > 23) ? longint'($floor(real'(mag) / (2.0 ** (e - 23)) + 0.5)) : (mag << (23 - e));
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    return {a[31], 8'(e + 127), 23'(q)};
  endfunction

  function automatic logic [31:0] m_ftoi(input logic [31:0] a);
    real v;
    longint mag;
    int e;
    e = int'(a[30:23]);
    v = real'(int'({1'b1, a[22:0]})) * (2.0 ** (e - 150));
    mag = longint'($floor(v + 0.5));
    return a[31] ? 32'(-mag) : 32'(mag);
  endfunction

  function automatic logic [31:0] m_conv(input fcvt_op_t op, input logic [31:0] d);
    return (op == OP_FTOI) ? m_ftoi(d) : m_itof(d);
  endfunction

  task automatic gen(output fcvt_op_t op, output logic [31:0] d);
    op = fcvt_op_t'($urandom_range(0, 1));
    if (op == OP_FTOI) d = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 157)), 23'($urandom)};
    else begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = d >> $urandom_range(0, 30);
    end
  endtask

  // scoreboard: grant/ready prediction, in-order results, output stability under stall
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      rr_m = 1'b0;
      stall_prev = 1'b0;
      acc0 = 1'b0;
      acc1 = 1'b0;
    end else begin
      both = req0_valid & req1_valid;
      g_m = both ? rr_m : req1_valid;
      exp_rdy = (sb.size() < 2 || res_ready) ? (g_m ? 2'b10 : 2'b01) : 2'b00;
      vectors++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL ready: got %b want %b at %0t", {req1_ready, req0_ready}, exp_rdy, $time);
      end
      if (stall_prev) begin
        vectors++;
        if ({res_valid, res_data, res_tag, res_src} !== snap) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", {res_valid, res_data, res_tag, res_src}, snap);
        end
      end
      if (res_valid && res_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result_extra: got data=%h tag=%0d src=%0d want none", res_data, res_tag, res_src);
        end else begin
          ex = sb.pop_front();
          if ({res_data, res_tag, res_src} !== {ex.data, ex.tag, ex.src}) begin
            errors++;
            $display("FAIL result: got %h/%0d/%0d want %h/%0d/%0d",
                     res_data, res_tag, res_src, ex.data, ex.tag, ex.src);
          end
        end
      end
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0) sb.push_back('{m_conv(req0_op, req0_data), req0_tag, 1'b0});
      if (acc1) sb.push_back('{m_conv(req1_op, req1_data), req1_tag, 1'b1});
      if (both && (acc0 || acc1)) rr_m = ~g_m;
      stall_prev = res_valid & ~res_ready;
      snap = {res_valid, res_data, res_tag, res_src};
    end
  end

  task automatic do_reset;
    rstn = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    if (res_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", res_data); end
    if (res_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d want 0", res_tag); end
    if (res_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b want 0", res_src); end
    rstn = 1'b1;
  endtask

  task automatic test_single_itof;
    @(posedge clk);
    #1 {req0_valid, req0_op, req0_data, req0_tag} = {1'b1, OP_ITOF, 32'h1, 5'd3};
    @(posedge clk);
    #1 req0_valid = 1'b0;
    vectors++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", res_valid); end
    @(posedge clk);
    #1;
    vectors++;
    if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'h3F800000, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_itof: got v=%b %h/%0d/%0d want v=1 3f800000/3/0", res_valid, res_data, res_tag, res_src);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_round_robin;
    do_reset;
    {req0_valid, req0_op, req0_data, req0_tag} = {1'b1, OP_ITOF, 32'hFFFFFFFE, 5'd1};
    {req1_valid, req1_op, req1_data, req1_tag} = {1'b1, OP_FTOI, 32'h40200000, 5'd2};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (i >= 2) begin
        vectors++;
        if ({res_valid, res_data, res_src} !== ((i % 2 == 0) ? {1'b1, 32'hC0000000, 1'b0} : {1'b1, 32'h00000003, 1'b1})) begin
          errors++;
          $display("FAIL rr_result[%0d]: got v=%b %h src=%b", i, res_valid, res_data, res_src);
        end
      end
    end
    @(posedge clk);
    #1 {req0_valid, req1_valid} = 2'b00;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ftoi_special;
    logic [31:0] ins [8] = '{32'hBFC00000, 32'h0, 32'h0, 32'h3F000000, 32'hBF000000, 32'h80000000, 32'h01000001, 32'h7FFFFFFF};
    logic [31:0] outs [8] = '{32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hCF000000, 32'h4B800001, 32'h4F000000};
    fcvt_op_t    ops [8] = '{OP_FTOI, OP_FTOI, OP_ITOF, OP_FTOI, OP_FTOI, OP_ITOF, OP_ITOF, OP_ITOF};
    bit got;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 {req1_valid, req1_op, req1_data, req1_tag} = {1'b1, ops[i], ins[i], 5'(i + 8)};
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        got = req1_ready;
      end
      @(posedge clk);
      #1 req1_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        got = res_valid;
      end
      vectors++;
      if (!got || res_data !== outs[i] || res_tag !== 5'(i + 8)) begin
        errors++;
        $display("FAIL special[%0d]: got v=%b %h tag=%0d want %h tag=%0d", i, got, res_data, res_tag, outs[i], i + 8);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_backpressure;
    int accepts;
    do_reset;
    res_ready = 1'b0;
    req0_valid = 1'b1;
    gen(req0_op, req0_data);
    req0_tag = 5'd0;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) accepts++;
      @(posedge clk);
      #1;
      if (acc0) begin
        gen(req0_op, req0_data);
        req0_tag = req0_tag + 5'd1;
      end
    end
    vectors += 2;
    if (accepts !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
    if ({res_valid, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_full: got valid=%b ready=%b want 1/0", res_valid, req0_ready);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (acc0) begin
        gen(req0_op, req0_data);
        req0_tag = req0_tag + 5'd1;
      end
    end
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_random;
    int c;
    do_reset;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!req0_valid || acc0) begin
        req0_valid = $urandom_range(0, 3) != 0;
        gen(req0_op, req0_data);
        req0_tag = 5'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = $urandom_range(0, 3) != 0;
        gen(req1_op, req1_data);
        req1_tag = 5'($urandom);
      end
      res_ready = $urandom_range(0, 3) != 0;
    end
    while ((req0_valid && !acc0) || (req1_valid && !acc1)) begin
      @(posedge clk);
      #1 res_ready = 1'b1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    c = 0;
    while (sb.size() != 0 && c < 20) begin
      @(posedge clk);
      c++;
    end
    #1;
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_reset_midflight;
    do_reset;
    res_ready = 1'b0;
    {req0_valid, req0_op, req0_data, req0_tag} = {1'b1, OP_ITOF, 32'd7, 5'd10};
    {req1_valid, req1_op, req1_data, req1_tag} = {1'b1, OP_ITOF, 32'd9, 5'd11};
    @(posedge clk);
    #1 {req0_data, req0_tag, req1_valid} = {32'd5, 5'd12, 1'b0};
    @(posedge clk);
    #1;
    vectors++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got %b want 1", res_valid); end
    rstn = 1'b0;
    res_ready = 1'b1;
    {req0_valid, req0_data, req0_tag} = {1'b1, 32'd3, 5'd20};
    {req1_valid, req1_data, req1_tag} = {1'b1, 32'd4, 5'd21};
    @(posedge clk);
    #1 rstn = 1'b1;
    vectors++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got %b want 0", res_valid); end
    @(negedge clk);
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_first_grant: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk);
    #1 {req0_valid, req1_valid} = 2'b00;
    vectors++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b want 0", res_valid); end
    @(posedge clk);
    #1;
    vectors++;
    if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'h40400000, 5'd20, 1'b0}) begin
      errors++;
      $display("FAIL mid_after: got v=%b %h/%0d/%0d want 1 40400000/20/0", res_valid, res_data, res_tag, res_src);
    end
    repeat (4) @(posedge clk);
  endtask

`ifdef FCVT_PERF_EN
  task automatic test_perf;
    do_reset;
    @(posedge clk);
    #1;
    {req0_valid, req0_op, req0_data, req0_tag} = {1'b1, OP_ITOF, 32'd2, 5'd1};
    {req1_valid, req1_op, req1_data, req1_tag} = {1'b1, OP_ITOF, 32'd6, 5'd2};
    repeat (10) @(posedge clk);
    #1 {req0_valid, req1_valid, res_ready} = 3'b000;
    repeat (3) @(posedge clk);
    #1 res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors += 2;
    if (perf_conflict !== 32'd10) begin errors++; $display("FAIL perf_conflict: got %0d want 10", perf_conflict); end
    if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", perf_stall); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_itof;
    test_round_robin;
    test_ftoi_special;
    test_backpressure;
    test_reset_midflight;
    test_random;
`ifdef FCVT_PERF_EN
    test_perf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
